// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: shared constants for the APB timer.
//   Register indices (paddr[4:2]), CTRL/STATUS bit positions, the
//   wait-state ceiling and a byte-strobe merge helper.
package apb_timer_pkg;

  localparam int REG_W = 32;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_LOAD   = 3'd1;
  localparam logic [2:0] REG_COUNT  = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int PRESCALE_LSB = 8;
  localparam int PRESCALE_MSB = 15;

  localparam int STATUS_EXPIRED = 0;

  localparam int WS_MAX = 15;

  // Byte lanes with strobe 0 keep the old value.
  function automatic logic [REG_W-1:0] merge_strb(
    input logic [REG_W-1:0]   old_val,
    input logic [REG_W-1:0]   new_val,
    input logic [REG_W/8-1:0] strb
  );
    logic [REG_W-1:0] res;
    for (int i = 0; i < REG_W/8; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_timer_if.sv
// apb_timer_if: APB completer bus bundle.
//   master modport: drives psel/penable/pwrite/paddr/pstrb/pwdata,
//                   receives prdata/pready/pslverr.
//   slave modport:  the reverse.
interface apb_timer_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW/8-1:0]   pstrb;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pstrb, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pstrb, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_timer_slave_if.sv
// apb_slave_if: APB completer front end.
//   Owns the wait-state counter, pready/pslverr generation, the
//   write-commit strobe and read-data gating.
//   Ports: clk, rst (async active-low), apb (slave modport),
//          rd_data (register mux from the core), reg_idx (paddr[4:2]),
//          wr_en (committed write to a mapped register), wdata, wstrb.
module apb_slave_if
  import apb_timer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW/8,
  parameter int WS = 1
) (
  input  logic          clk,
  input  logic          rst,
  apb_timer_if.slave    apb,
  input  logic [DW-1:0] rd_data,
  output logic [2:0]    reg_idx,
  output logic          wr_en,
  output logic [DW-1:0] wdata,
  output logic [SW-1:0] wstrb
);

  localparam logic [3:0] WS_CNT = 4'((WS > WS_MAX) ? WS_MAX : WS);

  logic [3:0] wcnt;
  logic       access;
  logic       ready;
  logic       mapped;
  logic       unused_addr;

  assign access  = apb.psel & apb.penable;
  assign reg_idx = apb.paddr[4:2];
  assign mapped  = (reg_idx <= REG_STATUS);

  // Gated by rst so an access in flight cannot complete while reset is held.
  assign ready = rst & access & (wcnt == WS_CNT);

  // Anything other than an access phase (setup, idle, dropped psel) clears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt <= '0;
    end else if (!access) begin
      wcnt <= '0;
    end else if (wcnt < WS_CNT) begin
      wcnt <= wcnt + 4'd1;
    end
  end

  assign apb.pready  = ready;
  assign apb.pslverr = ready & ~mapped;
  assign apb.prdata  = (ready & mapped & ~apb.pwrite) ? rd_data : '0;

  assign wr_en = ready & mapped & apb.pwrite;
  assign wdata = apb.pwdata;
  assign wstrb = apb.pstrb;

  assign unused_addr = ^{apb.paddr[AW-1:5], apb.paddr[1:0]};

endmodule

// File: rtl/apb_timer.sv
// apb_timer: prescaled down-counter timer behind an APB completer.
//   CTRL (0x00): [0] EN, [1] AUTO, [2] IRQ_EN, [15:8] PRESCALE
//   LOAD (0x04): reload value
//   COUNT(0x08): current count, R/W
//   STATUS(0x0C): [0] EXPIRED, write-1-to-clear
//   Ports: clk, rst (async active-low), apb (slave modport),
//          irq (registered EXPIRED & IRQ_EN).
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW/8,
  parameter int WS = 1
) (
  input  logic       clk,
  input  logic       rst,
  apb_timer_if.slave apb,
  output logic       irq
);

  logic [2:0]    reg_idx;
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [DW-1:0] rd_data;

  logic          en;
  logic          auto_rl;
  logic          irq_en;
  logic [7:0]    prescale;
  logic [DW-1:0] load;
  logic [DW-1:0] count;
  logic          expired;
  logic [7:0]    pcnt;

  logic          tick;
  logic          expire_now;
  logic [DW-1:0] ctrl_rd;

  apb_slave_if #(
    .AW (AW),
    .DW (DW),
    .SW (SW),
    .WS (WS)
  ) u_slv (
    .clk     (clk),
    .rst     (rst),
    .apb     (apb),
    .rd_data (rd_data),
    .reg_idx (reg_idx),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .wstrb   (wstrb)
  );

  always_comb begin
    ctrl_rd                            = '0;
    ctrl_rd[CTRL_EN]                   = en;
    ctrl_rd[CTRL_AUTO]                 = auto_rl;
    ctrl_rd[CTRL_IRQ_EN]               = irq_en;
    ctrl_rd[PRESCALE_MSB:PRESCALE_LSB] = prescale;
  end

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_CTRL:   rd_data = ctrl_rd;
      REG_LOAD:   rd_data = load;
      REG_COUNT:  rd_data = count;
      REG_STATUS: rd_data[STATUS_EXPIRED] = expired;
      default:    rd_data = '0;
    endcase
  end

  assign tick       = en & (pcnt == prescale);
  assign expire_now = tick & (count == '0);

  // Tick updates come first; bus writes later in the block override them
  // (COUNT write beats decrement, CTRL write beats the one-shot EN clear).
  // The W1C is suppressed when an expiry lands in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      irq_en   <= 1'b0;
      prescale <= '0;
      load     <= '0;
      count    <= '0;
      expired  <= 1'b0;
      pcnt     <= '0;
      irq      <= 1'b0;
    end else begin
      if (!en || tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 8'd1;
      end

      if (tick) begin
        if (count != '0) begin
          count <= count - 32'd1;
        end else begin
          expired <= 1'b1;
          if (auto_rl) begin
            count <= load;
          end else begin
            en <= 1'b0;
          end
        end
      end

      if (wr_en) begin
        case (reg_idx)
          REG_CTRL: begin
            if (wstrb[0]) begin
              en      <= wdata[CTRL_EN];
              auto_rl <= wdata[CTRL_AUTO];
              irq_en  <= wdata[CTRL_IRQ_EN];
            end
            if (wstrb[1]) begin
              prescale <= wdata[PRESCALE_MSB:PRESCALE_LSB];
            end
            pcnt <= '0;
          end
          REG_LOAD:  load  <= merge_strb(load, wdata, wstrb);
          REG_COUNT: count <= merge_strb(count, wdata, wstrb);
          REG_STATUS: begin
            if (wstrb[0] && wdata[STATUS_EXPIRED] && !expire_now) begin
              expired <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      irq <= expired & irq_en;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed and randomized checks of apb_timer against an
// arithmetic model of the timer (tick count -> count/expired/en).
module tb_apb_timer;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_LOAD   = 32'h04;
  localparam logic [31:0] A_COUNT  = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h0C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;

  apb_timer_if #(.AW(32), .DW(32)) apb ();

  apb_timer #(.AW(32), .DW(32), .WS(1)) dut (
    .clk (clk),
    .rst (rst),
    .apb (apb),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
  endtask

  // Starts just after a posedge; returns the cycle index at which pready
  // was sampled (the commit edge is that index + 1).
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output int acc, output int scyc);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = wr;
    apb.paddr   = addr;
    apb.pwdata  = data;
    apb.pstrb   = strb;
    rdata = '0;
    err   = 1'b0;
    acc   = 0;
    scyc  = -1;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc++;
      if (apb.pready === 1'b1) begin
        rdata = apb.prdata;
        err   = apb.pslverr;
        scyc  = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (scyc < 0) chk("xfer_timeout", {31'b0, apb.pready}, 32'd1);
    @(posedge clk); #1;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int ccyc);
    logic [31:0] d;
    logic        e;
    int          acc, s;
    xfer(1'b1, addr, data, 4'hF, d, e, acc, s);
    ccyc = s + 1;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output int s);
    logic e;
    int   acc;
    xfer(1'b0, addr, 32'h0, 4'h0, data, e, acc, s);
  endtask

  // n clock edges after the CTRL write that enabled the timer.
  function automatic void predict(input int n, input int start, input int ld, input bit aut,
                                  input int p, output int cnt, output bit exp_o, output bit en_o);
    int t;
    t = (n < 0) ? 0 : n / (p + 1);
    if (t <= start) begin
      cnt = start - t; exp_o = 1'b0; en_o = 1'b1;
    end else if (!aut) begin
      cnt = 0; exp_o = 1'b1; en_o = 1'b0;
    end else begin
      cnt = ld - ((t - start - 1) % (ld + 1)); exp_o = 1'b1; en_o = 1'b1;
    end
  endfunction

  initial begin
    logic [31:0] d;
    logic        e;
    int          acc, s, e0, ec, d0, pc;
    bit          pe, pen;

    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pstrb = '0; apb.pwdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_prdata", apb.prdata, 32'h0);
    chk("rst_pready", {31'b0, apb.pready}, 32'h0);
    chk("rst_pslverr", {31'b0, apb.pslverr}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset reads: two access cycles each, zero data, no error.
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 32'(4 * i), 32'h0, 4'h0, d, e, acc, s);
      chk($sformatf("rst_read%0d_data", i), d, 32'h0);
      chk($sformatf("rst_read%0d_err", i), {31'b0, e}, 32'h0);
      chk($sformatf("rst_read%0d_acc", i), 32'(acc), 32'd2);
    end

    // Unmapped accesses.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, acc, s);
    chk("unmapped_wr_err", {31'b0, e}, 32'h1);
    rd(A_CTRL, d, s);  chk("unmapped_wr_ctrl", d, 32'h0);
    rd(A_LOAD, d, s);  chk("unmapped_wr_load", d, 32'h0);
    rd(A_COUNT, d, s); chk("unmapped_wr_count", d, 32'h0);
    xfer(1'b0, 32'h1C, 32'h0, 4'h0, d, e, acc, s);
    chk("unmapped_rd_data", d, 32'h0);
    chk("unmapped_rd_err", {31'b0, e}, 32'h1);

    // Byte strobes.
    xfer(1'b1, A_LOAD, 32'hFFFFFFFF, 4'b0101, d, e, acc, s);
    chk("strb_wr_err", {31'b0, e}, 32'h0);
    rd(A_LOAD, d, s);  chk("strb_load", d, 32'h00FF00FF);

    // One-shot with interrupt.
    wr(A_COUNT, 32'd3, ec);
    wr(A_CTRL, 32'h5, e0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      predict(cyc - 1 - e0, 3, 0, 1'b0, 0, pc, pe, pen);
      chk($sformatf("oneshot_irq%0d", i), {31'b0, irq}, {31'b0, pe});
    end
    @(posedge clk); #1;
    rd(A_COUNT, d, s);  chk("oneshot_count", d, 32'h0);
    rd(A_STATUS, d, s); chk("oneshot_status", d, 32'h1);
    rd(A_CTRL, d, s);   chk("oneshot_ctrl", d, 32'h4);
    wr(A_STATUS, 32'h1, ec);
    @(negedge clk);     chk("w1c_irq_lag", {31'b0, irq}, 32'h1);
    @(negedge clk);     chk("w1c_irq_drop", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    rd(A_STATUS, d, s); chk("w1c_status", d, 32'h0);

    // Auto-reload, prescale 3.
    wr(A_CTRL, 32'h0, ec);
    wr(A_LOAD, 32'd2, ec);
    wr(A_COUNT, 32'd0, ec);
    wr(A_CTRL, 32'h303, e0);
    for (int i = 0; i < 6; i++) begin
      rd(A_COUNT, d, s);
      predict(s - e0, 0, 2, 1'b1, 3, pc, pe, pen);
      chk($sformatf("auto_count%0d", i), d, 32'(pc));
    end
    rd(A_STATUS, d, s);
    predict(s - e0, 0, 2, 1'b1, 3, pc, pe, pen);
    chk("auto_status", d, {31'b0, pe});
    rd(A_CTRL, d, s);   chk("auto_ctrl", d, 32'h303);

    // Randomized configurations against the arithmetic model.
    for (int it = 0; it < 8; it++) begin
      int st, ld, p, sel;
      bit au, ie;
      logic [31:0] cfg, addr, expv;
      st = $urandom_range(5);
      ld = $urandom_range(4);
      p  = $urandom_range(3);
      au = 1'($urandom_range(1));
      ie = 1'($urandom_range(1));
      cfg = (32'(p) << 8) | (32'(ie) << 2) | (32'(au) << 1) | 32'h1;
      wr(A_CTRL, 32'h0, ec);
      wr(A_STATUS, 32'h1, ec);
      wr(A_LOAD, 32'(ld), ec);
      wr(A_COUNT, 32'(st), ec);
      wr(A_CTRL, cfg, e0);
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(3)) begin @(posedge clk); #1; end
        sel = $urandom_range(2);
        addr = (sel == 0) ? A_COUNT : (sel == 1) ? A_STATUS : A_CTRL;
        rd(addr, d, s);
        predict(s - e0, st, ld, au, p, pc, pe, pen);
        expv = (sel == 0) ? 32'(pc) : (sel == 1) ? {31'b0, pe} : ((cfg & ~32'h1) | {31'b0, pen});
        chk($sformatf("rnd%0d_%0d_sel%0d", it, k, sel), d, expv);
      end
    end

    // COUNT write in a tick cycle (prescale 0: every cycle ticks).
    wr(A_CTRL, 32'h0, ec);
    wr(A_STATUS, 32'h1, ec);
    wr(A_COUNT, 32'd100, ec);
    wr(A_CTRL, 32'h1, e0);
    wr(A_COUNT, 32'h55, ec);
    rd(A_COUNT, d, s);
    chk("count_wr_wins", d, 32'h55 - 32'(s - ec));

    // W1C landing on the expiry edge.
    wr(A_CTRL, 32'h0, ec);
    wr(A_STATUS, 32'h1, ec);
    wr(A_LOAD, 32'd1000, ec);
    wr(A_COUNT, 32'd0, ec);
    wr(A_CTRL, 32'h203, e0);
    wr(A_STATUS, 32'h1, ec);
    chk("w1c_align", 32'(ec), 32'(e0 + 3));
    rd(A_STATUS, d, s); chk("expiry_beats_w1c", d, 32'h1);
    wr(A_STATUS, 32'h1, ec);
    rd(A_STATUS, d, s); chk("w1c_plain", d, 32'h0);

    // Reset in the middle of a read and a running count.
    wr(A_CTRL, 32'h0, ec);
    wr(A_LOAD, 32'd50, ec);
    wr(A_COUNT, 32'd0, ec);
    wr(A_CTRL, 32'h7, e0);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = A_COUNT;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_pready", {31'b0, apb.pready}, 32'h1);
    chk("pre_rst_irq", {31'b0, irq}, 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_prdata", apb.prdata, 32'h0);
    chk("mid_rst_pready", {31'b0, apb.pready}, 32'h0);
    chk("mid_rst_pslverr", {31'b0, apb.pslverr}, 32'h0);
    chk("mid_rst_irq", {31'b0, irq}, 32'h0);
    apb.psel = 1'b0; apb.penable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rd(A_COUNT, d, s);  chk("post_rst_count", d, 32'h0);
    rd(A_CTRL, d, s);   chk("post_rst_ctrl", d, 32'h0);
    rd(A_LOAD, d, s);   chk("post_rst_load", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
